// File: rtl/mfp_adc_max10_model_pkg.sv
// ============================================================================
// mfp_adc_max10_model_pkg : channel codes, FSM encoding and LFSR constants
// Revision 1.0
// ============================================================================
`default_nettype none

package mfp_adc_max10_model_pkg;

    localparam logic [4:0]  CH_TEMP_SENSOR      = 5'd17;
    localparam int          CONV_CYCLES_DEFAULT = 5;
    localparam int          CMD_W               = 7;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] ch;
        logic       sop;
        logic       eop;
    } cmd_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mfp_adc_max10_model_cmd_buf.sv
// ============================================================================
// adc_model_cmd_buf : one-entry command register with full flag, load and pop
// Revision 1.0
// ============================================================================
`default_nettype none

module adc_model_cmd_buf
    import mfp_adc_max10_model_pkg::*;
#(
    parameter int WIDTH = CMD_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/mfp_adc_max10_model.sv
// ============================================================================
// mfp_adc_max10_model : behavioural MAX10 modular ADC responder.
// Optional LSB noise when ADC_MODEL_NOISE_EN is defined.   Revision 1.0
// ============================================================================
`default_nettype none

module mfp_adc_max10_model
    import mfp_adc_max10_model_pkg::*;
#(
    parameter int          CONV_CYCLES   = CONV_CYCLES_DEFAULT,
    parameter int          DATA_WIDTH    = 12,
    parameter logic [31:0] VALID_CH_MASK = 32'h0003_FFFF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ADC_C_Valid,
    input  logic [4:0]            ADC_C_Channel,
    input  logic                  ADC_C_SOP,
    input  logic                  ADC_C_EOP,
    output logic                  ADC_C_Ready,
    output logic                  ADC_R_Valid,
    output logic [4:0]            ADC_R_Channel,
    output logic [DATA_WIDTH-1:0] ADC_R_Data,
    output logic                  ADC_R_SOP,
    output logic                  ADC_R_EOP,
    output logic [4:0]            analog_channel,
    input  logic [DATA_WIDTH-1:0] analog_data,
    output logic                  proto_err,
    input  logic                  err_clear
);

    localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    cmd_t                  cur_q, cur_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready_q;
    logic                  in_pkt_q, in_pkt_d;
    logic                  proto_err_q, proto_err_d;

    logic                  w_accept, w_pop, w_full, w_full_next, w_err;
    cmd_t                  w_cmd_in, w_buf_data;
    logic [DATA_WIDTH-1:0] w_sample;

    assign w_accept    = ADC_C_Valid & ready_q;
    assign w_cmd_in    = '{ch: ADC_C_Channel, sop: ADC_C_SOP, eop: ADC_C_EOP};
    assign w_full_next = (w_full & ~w_pop) | w_accept;

    adc_model_cmd_buf #(.WIDTH(CMD_W)) u_cmd_buf (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .load_i (w_accept),
        .data_i (w_cmd_in),
        .pop_i  (w_pop),
        .full_o (w_full),
        .data_o (w_buf_data)
    );

`ifdef ADC_MODEL_NOISE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign w_sample = VALID_CH_MASK[cur_q.ch]
                    ? (analog_data ^ {{(DATA_WIDTH-2){1'b0}}, lfsr_q[1:0]})
                    : '0;
`else
    assign w_sample = VALID_CH_MASK[cur_q.ch] ? analog_data : '0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            in_pkt_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            data_q      <= data_d;
            ready_q     <= ~w_full_next;
            in_pkt_q    <= in_pkt_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        data_d  = data_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (w_full) begin
                    state_d = ST_CONV;
                    cur_d   = w_buf_data;
                    cnt_d   = CNT_LOAD;
                    w_pop   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    data_d  = w_sample;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Framing is judged on accept only; errors never stall the stream.
    always_comb begin
        in_pkt_d    = in_pkt_q;
        w_err       = 1'b0;
        if (w_accept) begin
            w_err = (ADC_C_SOP & in_pkt_q) | (~ADC_C_SOP & ~in_pkt_q)
                  | ~VALID_CH_MASK[ADC_C_Channel];
            if (ADC_C_EOP) begin
                in_pkt_d = 1'b0;
            end else if (ADC_C_SOP) begin
                in_pkt_d = 1'b1;
            end
        end
        proto_err_d = w_err ? 1'b1 : (err_clear ? 1'b0 : proto_err_q);
    end

    always_comb begin
        ADC_R_Valid    = (state_q == ST_RESP);
        ADC_R_Channel  = ADC_R_Valid ? cur_q.ch  : 5'd0;
        ADC_R_Data     = ADC_R_Valid ? data_q    : '0;
        ADC_R_SOP      = ADC_R_Valid & cur_q.sop;
        ADC_R_EOP      = ADC_R_Valid & cur_q.eop;
        analog_channel = (state_q == ST_CONV) ? cur_q.ch : 5'd0;
        ADC_C_Ready    = ready_q;
        proto_err      = proto_err_q;
    end

endmodule

`default_nettype wire
